pc_sequencer: RTL
=================

// Module: pc_sequencer
// PURPOSE
//  Next-PC controller that owns the program-counter register for the fetch stage.
//  Each cycle it picks one next PC: sequential (+INSTR_BYTES), branch target, exception vector or hold.
//  It drives pipeline flush on redirects, supports halt/resume, and counts redirects for performance monitoring.
//  Sits between the execute/branch unit and instruction fetch.
// PARAMETERS
//  DATA_WIDTH   64      PC / target width in bits
//  INSTR_BYTES  4       sequential increment, power of two
//  RESET_VECTOR 64'h0   PC loaded on reset
//  EXC_VECTOR   64'h100 PC loaded on an exception request
//  CNT_WIDTH    16      width of the saturating redirect counter
// PORTS
//  clk            in   1           clock, rising edge
//  reset          in   1           asynchronous reset, active-low (0 = reset)
//  stall          in   1           hold the current PC (fetch back-pressure)
//  branch_taken   in   1           redirect to branch_target
//  branch_target  in   DATA_WIDTH  branch destination
//  exc_req        in   1           redirect to EXC_VECTOR
//  halt_req       in   1           stop fetching
//  resume         in   1           leave HALT
//  pc             out  DATA_WIDTH  current fetch PC (registered)
//  pc_valid       out  1           pc is a real fetch address this cycle
//  flush          out  1           kill younger in-flight instructions
//  halted         out  1           state == HALT
//  redirect_cnt   out  CNT_WIDTH   number of redirects taken, saturating
// BEHAVIOUR
//  Reset (reset==0, asynchronous)
//   - state=BOOT, pc=RESET_VECTOR, pc_valid=0, flush=0, halted=0, redirect_cnt=0.
//   - Asserting reset mid-operation abandons any redirect in progress.
//  States: BOOT, RUN, REDIRECT, HALT (encoded 2 bits)
//   - BOOT: one cycle after reset is released -> RUN; pc unchanged.
//  RUN (pc_valid=1), evaluated in priority order:
//   1. exc_req: pc<=EXC_VECTOR, ->REDIRECT.
//   2. branch_taken: pc<=branch_target, ->REDIRECT.
//   3. halt_req: pc held, ->HALT.
//   4. stall: pc held, stay RUN.
//   5. otherwise: pc<=pc+INSTR_BYTES, truncated to DATA_WIDTH (wraps from all-ones).
//   - A redirect (items 1-2) overrides stall.
//  REDIRECT (one cycle)
//   - pc_valid=0, flush=1; pc already holds the new target.
//   - Next state: RUN, pc unchanged; a new exc_req is honoured as another redirect.
//   - Latency: request in cycle N; flush in N+1; target fetched valid in N+2.
//  HALT
//   - pc_valid=0, halted=1, pc held.
//   - exc_req -> REDIRECT to EXC_VECTOR.
//   - else resume -> RUN.
//   - Branches are ignored.
//  Outputs and counter
//   - flush, pc_valid and halted are registered outputs decoded from state.
//   - redirect_cnt increments on each entry into REDIRECT; it holds at all-ones.
// CONFIGURATION
//  PC_SEQ_ALIGN_CHECK_EN
//   - Defined: a branch whose target low log2(INSTR_BYTES) bits are nonzero is treated as exc_req.
//     It redirects to EXC_VECTOR and sets sticky output align_fault (1 bit, cleared only by reset).
//   - Undefined: no align_fault port; the target is loaded unmodified.
// STRUCTURE
//  - Package arm_cpu_pkg holds the pc_seq_state_t state encoding and the INSTR_BYTES / vector constants.
//  - One sub-module, pc_sat_counter: the saturating counter, parameterised by CNT_WIDTH.
//  - FSM and PC register live in this module.
// TESTING
//  - Reset: hold reset=0 with random inputs -> pc=0, pc_valid=0, cnt=0.
//    Release reset -> BOOT for one cycle, then pc 0,4,8,... with pc_valid=1.
//  - Branch: branch_taken=1, target=0x2000 at pc=0x10 -> next cycle flush=1 and pc_valid=0.
//    Following cycle pc=0x2000 valid, then 0x2004; redirect_cnt=1.
//  - Same cycle: exc_req, branch_taken and stall all asserted -> pc=0x100, exc vector wins.
//    stall=1 alone for 3 cycles -> pc frozen.
//  - Halt/resume: halt_req at pc=0x40 -> halted=1, pc=0x40 held, branch ignored.
//    resume -> pc_valid=1 at 0x40, then 0x44.
//  - Wrap: branch to 0xFFFF_FFFF_FFFF_FFFC -> next sequential pc=0x0.
//    Force 65535 redirects -> redirect_cnt stays 0xFFFF.
//  - Align (macro on): branch to 0x2002 -> pc=0x100 and align_fault=1, sticky until reset.

Source files
------------

// File: rtl/arm_cpu_pkg.sv
// Package: arm_cpu_pkg
// Shared constants for the fetch-side next-PC logic:
//   - pc_seq_state_t : 2-bit state encoding of the pc_sequencer FSM
//   - PC_INSTR_BYTES : default sequential increment
//   - PC_RESET_VECTOR / PC_EXC_VECTOR : default boot and exception addresses
package arm_cpu_pkg;

  typedef logic [1:0] pc_seq_state_t;

  localparam pc_seq_state_t ST_BOOT     = 2'd0;
  localparam pc_seq_state_t ST_RUN      = 2'd1;
  localparam pc_seq_state_t ST_REDIRECT = 2'd2;
  localparam pc_seq_state_t ST_HALT     = 2'd3;

  localparam int          PC_INSTR_BYTES  = 4;
  localparam logic [63:0] PC_RESET_VECTOR = 64'h0;
  localparam logic [63:0] PC_EXC_VECTOR   = 64'h100;

endpackage

// File: rtl/pc_sat_counter.sv
// Module: pc_sat_counter
// Saturating up-counter; sticks at all-ones.
// Ports:
//   clk    in  clock, rising edge
//   reset  in  asynchronous reset, active-low
//   inc    in  count one event this cycle
//   count  out current count (WIDTH bits)
module pc_sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (inc && (count != {WIDTH{1'b1}})) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Module: pc_sequencer
// Next-PC controller owning the fetch PC register. Each cycle it selects
// sequential, branch target, exception vector or hold, drives flush on
// redirects, supports halt/resume and counts redirects (saturating).
//
// Optional feature macro: PC_SEQ_ALIGN_CHECK_EN
//   When defined, a taken branch with a misaligned target is redirected to
//   EXC_VECTOR instead and the sticky align_fault output is set.
//
// Ports:
//   clk            in   clock, rising edge
//   reset          in   asynchronous reset, active-low
//   stall          in   hold current PC
//   branch_taken   in   redirect to branch_target
//   branch_target  in   branch destination
//   exc_req        in   redirect to EXC_VECTOR
//   halt_req       in   stop fetching
//   resume         in   leave HALT
//   pc             out  current fetch PC (registered)
//   pc_valid       out  pc is a real fetch address
//   flush          out  kill younger in-flight instructions
//   halted         out  FSM is in HALT
//   align_fault    out  sticky misaligned-branch flag (macro builds only)
//   redirect_cnt   out  saturating redirect count
//
// state    | meaning
// ---------+---------------------------------------------------------
// BOOT     | first cycle after reset release, pc = RESET_VECTOR
// RUN      | fetching; pc_valid = 1
// REDIRECT | new target already in pc; flush = 1, pc_valid = 0
// HALT     | fetch stopped; halted = 1, pc held
module pc_sequencer
  import arm_cpu_pkg::*;
#(
  parameter int                    DATA_WIDTH   = 64,
  parameter int                    INSTR_BYTES  = PC_INSTR_BYTES,
  parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = DATA_WIDTH'(PC_RESET_VECTOR),
  parameter logic [DATA_WIDTH-1:0] EXC_VECTOR   = DATA_WIDTH'(PC_EXC_VECTOR),
  parameter int                    CNT_WIDTH    = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  branch_taken,
  input  logic [DATA_WIDTH-1:0] branch_target,
  input  logic                  exc_req,
  input  logic                  halt_req,
  input  logic                  resume,
  output logic [DATA_WIDTH-1:0] pc,
  output logic                  pc_valid,
  output logic                  flush,
  output logic                  halted,
`ifdef PC_SEQ_ALIGN_CHECK_EN
  output logic                  align_fault,
`endif
  output logic [CNT_WIDTH-1:0]  redirect_cnt
);

  pc_seq_state_t         state, state_nxt;
  logic [DATA_WIDTH-1:0] pc_nxt;
  logic                  redirect_take;
  logic                  branch_bad;

`ifdef PC_SEQ_ALIGN_CHECK_EN
  localparam logic [DATA_WIDTH-1:0] ALIGN_MASK = DATA_WIDTH'(INSTR_BYTES - 1);
  assign branch_bad = |(branch_target & ALIGN_MASK);
`else
  assign branch_bad = 1'b0;
`endif

  always_comb begin
    state_nxt     = state;
    pc_nxt        = pc;
    redirect_take = 1'b0;
    case (state)
      ST_BOOT: begin
        state_nxt = ST_RUN;
      end
      ST_RUN: begin
        // Redirects outrank halt and stall.
        if (exc_req || (branch_taken && branch_bad)) begin
          pc_nxt        = EXC_VECTOR;
          state_nxt     = ST_REDIRECT;
          redirect_take = 1'b1;
        end else if (branch_taken) begin
          pc_nxt        = branch_target;
          state_nxt     = ST_REDIRECT;
          redirect_take = 1'b1;
        end else if (halt_req) begin
          state_nxt = ST_HALT;
        end else if (!stall) begin
          pc_nxt = pc + DATA_WIDTH'(INSTR_BYTES);
        end
      end
      ST_REDIRECT: begin
        // Back-to-back exceptions re-enter REDIRECT; branches wait for RUN.
        if (exc_req) begin
          pc_nxt        = EXC_VECTOR;
          redirect_take = 1'b1;
        end else begin
          state_nxt = ST_RUN;
        end
      end
      default: begin  // ST_HALT
        if (exc_req) begin
          pc_nxt        = EXC_VECTOR;
          state_nxt     = ST_REDIRECT;
          redirect_take = 1'b1;
        end else if (resume) begin
          state_nxt = ST_RUN;
        end
      end
    endcase
  end

  // Status outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_BOOT;
      pc       <= RESET_VECTOR;
      pc_valid <= 1'b0;
      flush    <= 1'b0;
      halted   <= 1'b0;
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      pc_valid <= (state_nxt == ST_RUN);
      flush    <= (state_nxt == ST_REDIRECT);
      halted   <= (state_nxt == ST_HALT);
    end
  end

`ifdef PC_SEQ_ALIGN_CHECK_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      align_fault <= 1'b0;
    end else if ((state == ST_RUN) && !exc_req && branch_taken && branch_bad) begin
      align_fault <= 1'b1;
    end
  end
`endif

  pc_sat_counter #(
    .WIDTH(CNT_WIDTH)
  ) u_redirect_cnt (
    .clk  (clk),
    .reset(reset),
    .inc  (redirect_take),
    .count(redirect_cnt)
  );

endmodule
